imem_fetch_resp: RTL and testbench
==================================

Name: imem_fetch_resp

Overview:
- Instruction-memory responder on the fetch side of the single-issue datapath.
- Accepts one fetch request (byte address from the program-counter block) and returns one 16-bit instruction after a fixed, parameterised latency.
- Drives Stall back to the PC logic so the PC holds while a fetch is outstanding; flags misaligned fetches.
- Provides a bench/loader write port for preloading program words.

Parameters:
- ADDR_W, 16, width of the byte address from the PC.
- DEPTH_LOG2, 8, log2 of the number of 16-bit words in the array (256 words).
- LATENCY, 2, edges from request capture to response; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Rd  in  1  fetch request, qualified by Addr.
- Addr  in  ADDR_W  byte address of the instruction.
- LoadEn  in  1  preload write enable.
- LoadAddr  in  ADDR_W  preload byte address; bit 0 ignored.
- LoadData  in  16  preload word.
- DataOut  out  16  fetched instruction; valid only while Done=1.
- Done  out  1  one-cycle response strobe.
- Stall  out  1  high while a fetch is in flight; the PC must hold.
- Err  out  1  misaligned fetch; valid only while Done=1.

Behaviour:
- Reset:
  - State returns to IDLE; the internal counter clears.
  - DataOut=0, Done=0, Stall=0, Err=0.
  - Array contents are not reset.
  - Reset asserted mid-fetch abandons the fetch: no Done is ever produced for it.
- States: IDLE, BUSY, RESP.
  - IDLE, Rd=1: capture Addr, load counter with LATENCY-1, go to BUSY.
  - BUSY, counter>0: decrement counter.
  - BUSY, counter=0: register the response and go to RESP.
  - RESP, Rd=1: capture the new request and go to BUSY (back-to-back, no bubble).
  - RESP, Rd=0: go to IDLE.
- Timing:
  - Rd sampled high at edge E0 produces Done=1 during exactly the cycle after edge E0+LATENCY.
  - Stall=1 exactly while state is BUSY.
  - Done=1 exactly while state is RESP.
  - LATENCY=1 gives one Stall cycle, then Done.
- Rd during BUSY is ignored; the captured address is used.
  - The requester holds Rd and Addr stable while Stall=1.
  - A changing Addr in BUSY does not affect the outstanding fetch.
- Indexing: word index = captured Addr[DEPTH_LOG2:1]. Upper address bits are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+1) bytes.
- Misalignment: captured Addr[0]=1 produces Err=1 and DataOut=0 in the RESP cycle. The array is not read.
- Aligned fetch: Err=0; DataOut = array word read at the BUSY->RESP edge.
- Load port:
  - LoadEn=1 writes LoadData to word LoadAddr[DEPTH_LOG2:1] at the edge, in any state.
  - Load and read of the same word at the same BUSY->RESP edge returns the old (pre-write) value.
  - A load at any earlier edge is visible to the fetch.
- Outputs are registered; no combinational path from Rd or Addr to any output.

Test Plan:
- Reset/idle: preload word 0x0004=0xA5C3, rst=1 for 2 cycles -> Done=0, Stall=0, Err=0, DataOut=0; array still holds 0xA5C3 afterwards.
- Basic fetch, LATENCY=2: Rd=1, Addr=0x0004 sampled at E0 -> Stall=1 for 2 cycles, then Done=1 for 1 cycle with DataOut=0xA5C3, Err=0; Done=0 next cycle with Rd=0.
- Back-to-back: words 0x0000=0x1111 and 0x0002=0x2222; Rd held high, Addr advanced by 2 in each RESP cycle -> Done every LATENCY+1 cycles returning 0x1111 then 0x2222; no IDLE cycle in between.
- Misaligned and wrap:
  - Addr=0x0005 -> Done=1, Err=1, DataOut=0.
  - With DEPTH_LOG2=8, Addr=0x0204 -> returns the same word as 0x0004 (0xA5C3), Err=0.
- Hazards:
  - Changing Addr to 0x0006 while BUSY -> the response is still word 0x0004.
  - LoadEn to 0x0004 with 0xBEEF at the BUSY->RESP edge -> DataOut=0xA5C3; a re-fetch then returns 0xBEEF.
- Reset mid-fetch: rst=1 one cycle after the request -> Stall=0 next cycle, no Done ever issued for that request, and a new Rd is accepted normally.

Source files
------------

// File: rtl/imem_fetch_resp.sv
// Instruction-memory fetch responder: one 16-bit word per request after a
// fixed latency, with Stall held while the fetch is outstanding.
module imem_fetch_resp #(
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Rd,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [15:0]       LoadData,
    output logic [15:0]       DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              Err
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [3:0] LP_CNT0 = 4'(LATENCY - 1);

    logic [15:0]           r_mem [2**DEPTH_LOG2];
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2:0]   r_addr;
    logic [15:0]           r_data;
    logic                  r_done;
    logic                  r_stall;
    logic                  r_err;

    logic [DEPTH_LOG2-1:0] w_ridx;
    logic [DEPTH_LOG2-1:0] w_lidx;
    logic                  w_unused;

    assign w_ridx = r_addr[DEPTH_LOG2:1];
    assign w_lidx = LoadAddr[DEPTH_LOG2:1];

    // Upper address bits wrap away by design.
    assign w_unused = ^{Addr[ADDR_W-1:DEPTH_LOG2+1],
                        LoadAddr[ADDR_W-1:DEPTH_LOG2+1],
                        LoadAddr[0]};

    always_ff @(posedge clk) begin
        if (LoadEn) begin
            r_mem[w_lidx] <= LoadData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_stall <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (Rd) begin
                        r_addr  <= Addr[DEPTH_LOG2:0];
                        r_cnt   <= LP_CNT0;
                        r_stall <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Misaligned fetches never touch the array.
                        r_err   <= r_addr[0];
                        r_data  <= r_addr[0] ? 16'h0000 : r_mem[w_ridx];
                        r_done  <= 1'b1;
                        r_stall <= 1'b0;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (Rd) begin
                        r_addr  <= Addr[DEPTH_LOG2:0];
                        r_cnt   <= LP_CNT0;
                        r_stall <= 1'b1;
                        r_state <= BUSY;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_stall <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign DataOut = r_data;
    assign Done    = r_done;
    assign Stall   = r_stall;
    assign Err     = r_err;

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Bench for imem_fetch_resp: vector table of single fetches plus
// hand-written back-to-back, hazard and reset sequences.
module tb_imem_fetch_resp;

    localparam int AW  = 16;
    localparam int DL  = 8;
    localparam int LAT = 2;

    logic          clk;
    logic          rst;
    logic          Rd;
    logic [AW-1:0] Addr;
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [15:0]   LoadData;
    logic [15:0]   DataOut;
    logic          Done;
    logic          Stall;
    logic          Err;

    int checks;
    int errors;

    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        err;
    } vec_t;

    exp_t q[$];
    vec_t vecs[9];

    imem_fetch_resp #(
        .ADDR_W(AW),
        .DEPTH_LOG2(DL),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Rd(Rd),
        .Addr(Addr),
        .LoadEn(LoadEn),
        .LoadAddr(LoadAddr),
        .LoadData(LoadData),
        .DataOut(DataOut),
        .Done(Done),
        .Stall(Stall),
        .Err(Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every Done pops one expected response.
    always @(negedge clk) begin
        if (Done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 expected none");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data", {16'h0, DataOut}, {16'h0, e.d});
                chk("err", {31'h0, Err}, {31'h0, e.e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        LoadEn   = 1'b1;
        LoadAddr = a;
        LoadData = d;
        tick();
        LoadEn   = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (Done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (Done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no Done expected Done", name);
        end
    endtask

    task automatic do_fetch(input string name, input logic [15:0] a,
                            input logic [15:0] d, input logic e);
        int n;
        Rd   = 1'b1;
        Addr = a;
        q.push_back('{d: d, e: e});
        tick();
        Rd = 1'b0;
        chk({name, "_stall"}, {31'h0, Stall}, 32'd1);
        wait_done(name, n);
        chk({name, "_lat"}, n, LAT);
        tick();
        chk({name, "_done_low"}, {31'h0, Done}, 32'd0);
    endtask

    initial begin
        int n;
        int t1;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        Rd       = 1'b0;
        Addr     = '0;
        LoadEn   = 1'b0;
        LoadAddr = '0;
        LoadData = '0;

        vecs[0] = '{16'h0004, 16'hA5C3, 1'b0};
        vecs[1] = '{16'h0005, 16'h0000, 1'b1};
        vecs[2] = '{16'h0204, 16'hA5C3, 1'b0};
        vecs[3] = '{16'h0000, 16'h1111, 1'b0};
        vecs[4] = '{16'h0002, 16'h2222, 1'b0};
        vecs[5] = '{16'h0006, 16'h0666, 1'b0};
        vecs[6] = '{16'hFFFF, 16'h0000, 1'b1};
        vecs[7] = '{16'h01FE, 16'h7E7E, 1'b0};
        vecs[8] = '{16'hFFFE, 16'h7E7E, 1'b0};

        load(16'h0004, 16'hA5C3);
        tick();
        chk("rst_done", {31'h0, Done}, 32'd0);
        chk("rst_stall", {31'h0, Stall}, 32'd0);
        chk("rst_err", {31'h0, Err}, 32'd0);
        chk("rst_data", {16'h0, DataOut}, 32'd0);
        rst = 1'b0;

        load(16'h0000, 16'h1111);
        load(16'h0002, 16'h2222);
        load(16'h0006, 16'h0666);
        load(16'h01FE, 16'h7E7E);
        tick();

        for (int i = 0; i < 9; i++) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].addr,
                     vecs[i].data, vecs[i].err);
        end

        // Back-to-back with Rd held high.
        Rd   = 1'b1;
        Addr = 16'h0000;
        q.push_back('{d: 16'h1111, e: 1'b0});
        tick();
        wait_done("b2b0", n);
        t1   = n;
        Addr = 16'h0002;
        q.push_back('{d: 16'h2222, e: 1'b0});
        tick();
        chk("b2b_no_bubble", {31'h0, Stall}, 32'd1);
        wait_done("b2b1", n);
        chk("b2b_spacing", n + 1, LAT + 1);
        chk("b2b_first_lat", t1, LAT);
        Rd = 1'b0;
        tick();
        chk("b2b_idle_done", {31'h0, Done}, 32'd0);
        chk("b2b_idle_stall", {31'h0, Stall}, 32'd0);

        // Address changes while BUSY must not matter.
        Rd   = 1'b1;
        Addr = 16'h0004;
        q.push_back('{d: 16'hA5C3, e: 1'b0});
        tick();
        Rd   = 1'b0;
        Addr = 16'h0006;
        wait_done("addr_chg", n);
        tick();

        // Load to the same word at the BUSY->RESP edge.
        Rd   = 1'b1;
        Addr = 16'h0004;
        q.push_back('{d: 16'hA5C3, e: 1'b0});
        tick();
        Rd = 1'b0;
        for (int i = 0; i < LAT - 1; i++) tick();
        load(16'h0004, 16'hBEEF);
        chk("hz_done", {31'h0, Done}, 32'd1);
        tick();
        do_fetch("refetch", 16'h0004, 16'hBEEF, 1'b0);

        // Reset one cycle after the request: no Done for it.
        Rd   = 1'b1;
        Addr = 16'h0002;
        tick();
        Rd  = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_stall", {31'h0, Stall}, 32'd0);
        chk("mid_rst_done", {31'h0, Done}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < LAT + 4; i++) tick();
        do_fetch("post_rst", 16'h0000, 16'h1111, 1'b0);

        tick();
        tick();
        chk("sb_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
